// File: rtl/hpdl_pkg.sv
// Shared definitions for the HPDL character display blocks: the dump FSM
// state encoding, ASCII control codes, the default display length and the
// baud divisor helper.
package hpdl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE,
    S_TERM
  } dump_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] BKSP     = 8'h08;

  localparam int DISPLAY_LENGTH_DEF = 16;

  // Clock cycles per serial bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// 8N1 frame serialiser: a load strobe captures one byte, then the line
// carries start bit, 8 data bits LSB first and a stop bit, DIV cycles each.
// Bit-end and frame-end strobes let a controller follow frame progress.
module uart_tx_frame
  import hpdl_pkg::*;
#(
  parameter int DIV = baud_div(12000000, 115200)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_bit_done,
  output logic [3:0] o_bit_idx,
  output logic       o_frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_div_cnt;
  logic [3:0]    r_bit_idx;
  logic [8:0]    r_shift;
  logic          r_active;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = r_active && (r_div_cnt == CW'(DIV - 1));

  // Baud and bit counters plus shift register; the stop bit rides in r_shift[8].
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '1;
      r_active  <= 1'b0;
      r_tx      <= 1'b1;
    end else if (i_load) begin
      r_div_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= {1'b1, i_byte};
      r_active  <= 1'b1;
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_div_cnt <= '0;
        if (r_bit_idx == 4'd9) begin
          r_active  <= 1'b0;
          r_bit_idx <= '0;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign o_tx         = r_tx;
  assign o_bit_done   = w_bit_end;
  assign o_bit_idx    = r_bit_idx;
  assign o_frame_done = w_bit_end && (r_bit_idx == 4'd9);

endmodule

// File: rtl/uart_display_dump.sv
// Reads the HPDL character memory out over the serial line on request.
// Each place costs a one-cycle read (FETCH), a capture cycle and one frame.
// Optional build macro DUMP_CRLF_EN appends CR and LF frames after the last
// character; o_done then follows the LF stop bit.
module uart_display_dump
  import hpdl_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int BAUD           = 115200,
  parameter int DISPLAY_LENGTH = DISPLAY_LENGTH_DEF,
  parameter int ADDR_W         = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_dump_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [7:0]        i_rd_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DISPLAY_LENGTH - 1);

  dump_state_t       r_state;
  dump_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic              w_load;
  logic [7:0]        w_load_byte;
  logic              w_bit_done;
  logic [3:0]        w_bit_idx;
  logic              w_frame_done;
`ifdef DUMP_CRLF_EN
  logic [1:0]        r_term_cnt;
  logic              r_term_gap;
`endif

  uart_tx_frame #(
    .DIV(DIV)
  ) u_frame (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .i_load      (w_load),
    .i_byte      (w_load_byte),
    .o_tx        (o_tx),
    .o_bit_done  (w_bit_done),
    .o_bit_idx   (w_bit_idx),
    .o_frame_done(w_frame_done)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and frame load; requests are only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_byte = i_rd_data;
    case (r_state)
      S_IDLE:    if (i_dump_req) w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_load      = 1'b1;
        w_state_nxt = S_START;
      end
      S_START:   if (w_bit_done) w_state_nxt = S_DATA;
      S_DATA:    if (w_bit_done && (w_bit_idx == 4'd8)) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_frame_done) begin
          if (r_idx != LAST_IDX) begin
            w_state_nxt = S_FETCH;
          end else begin
`ifdef DUMP_CRLF_EN
            w_state_nxt = (r_term_cnt == 2'd2) ? S_DONE : S_TERM;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
`ifdef DUMP_CRLF_EN
      // Two cycles here mirror FETCH+CAPTURE so the inter-frame gap matches.
      S_TERM: begin
        if (r_term_gap) begin
          w_load      = 1'b1;
          w_load_byte = (r_term_cnt == 2'd1) ? ASCII_CR : ASCII_LF;
          w_state_nxt = S_START;
        end
      end
`endif
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Character index; it only moves on entry to FETCH, so it doubles as the read address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx <= '0;
    end else if ((r_state == S_IDLE) && i_dump_req) begin
      r_idx <= '0;
    end else if ((r_state == S_STOP) && w_frame_done && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + 1'b1;
    end
  end

`ifdef DUMP_CRLF_EN
  // Terminator sequencing: count 1 selects CR, count 2 selects LF.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_term_cnt <= 2'd0;
      r_term_gap <= 1'b0;
    end else if ((r_state == S_IDLE) && i_dump_req) begin
      r_term_cnt <= 2'd0;
      r_term_gap <= 1'b0;
    end else if ((r_state == S_STOP) && w_frame_done && (r_idx == LAST_IDX) &&
                 (r_term_cnt != 2'd2)) begin
      r_term_cnt <= r_term_cnt + 2'd1;
      r_term_gap <= 1'b0;
    end else if (r_state == S_TERM) begin
      r_term_gap <= ~r_term_gap;
    end
  end
`endif

  assign o_rd_addr = r_idx;
  assign o_rd_en   = (r_state == S_FETCH);
  assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done    = (r_state == S_DONE);

endmodule
